// File: rtl/rv_sender.sv
// -----------------------------------------------------------------------------
// rv_sender
//   Transmit end of a registered ready/valid link. Local logic pushes words
//   into a small FIFO. The head of the FIFO is presented on a registered
//   out_valid/out_data pair. A word retires only on a cycle where
//   out_valid && out_ready is sampled at the clock edge.
//   Total storage is the output register plus DEPTH FIFO entries.
//
// Ports
//   clk, rst      rising-edge clock; asynchronous active-high reset
//   push          upstream write strobe
//   push_data     word accepted when push && !full
//   full          no free storage; depends only on registered state
//   out_valid     registered; out_data holds a word awaiting transfer
//   out_data      registered payload
//   out_ready     consumer ready; ignored while out_valid is low
//   sent_count    completed transfers, wraps modulo 2^CNT_W
//   overflow      sticky; a push arrived while full
//   idle          FIFO empty and output register empty
// -----------------------------------------------------------------------------
module rv_sender #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] sent_count,
   output logic             overflow,
   output logic             idle
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // FIFO storage and pointers
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   // Output register and status
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_W-1:0] sent_count_q, sent_count_d;
   logic             overflow_q, overflow_d;

   // Handshake and steering
   logic fire;
   logic fifo_empty;
   logic full_int;
   logic load_en;
   logic push_ok;
   logic head_load;
   logic bypass;
   logic fifo_wr;
   logic fifo_rd;

   always_comb begin
      fire       = out_valid_q && out_ready;
      fifo_empty = (count_q == '0);
      // Full is judged before any pop this cycle, so a push coinciding with
      // a fire while full is still rejected.
      full_int   = (count_q == CW'(DEPTH)) && out_valid_q;
      load_en    = !out_valid_q || fire;
      push_ok    = push && !full_int;
      head_load  = load_en && !fifo_empty;
      // Bypass only when the FIFO is empty; otherwise the new word would
      // overtake older buffered words.
      bypass     = load_en && fifo_empty && push_ok;
      fifo_wr    = push_ok && !bypass;
      fifo_rd    = head_load;
   end

   // Pointer / occupancy next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (fifo_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (fifo_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({fifo_wr, fifo_rd})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO write data
   always_comb begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
      if (fifo_wr) mem_d[wr_ptr_q] = push_data;
   end

   // Output register next state
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (head_load) begin
         out_valid_d = 1'b1;
         out_data_d  = mem_q[rd_ptr_q];
      end else if (bypass) begin
         out_valid_d = 1'b1;
         out_data_d  = push_data;
      end else if (fire) begin
         out_valid_d = 1'b0;
      end
   end

   // Status next state
   always_comb begin
      sent_count_d = sent_count_q;
      overflow_d   = overflow_q;
      if (fire) sent_count_d = sent_count_q + CNT_W'(1);
      if (push && full_int) overflow_d = 1'b1;
   end

   // Storage array carries no reset; stale entries are never read because
   // occupancy is cleared.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         sent_count_q <= '0;
         overflow_q   <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         sent_count_q <= sent_count_d;
         overflow_q   <= overflow_d;
      end
   end

   assign full       = full_int;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign sent_count = sent_count_q;
   assign overflow   = overflow_q;
   assign idle       = fifo_empty && !out_valid_q;

endmodule
